// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory, with a bounded master-1 lock
// and read-data return routing. Define DMEM_ARB_PERF_EN to add conflict/grant counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       m1_grant_cnt
`endif
);
    typedef enum logic {PRIO_M0 = 1'b0, PRIO_M1 = 1'b1} prio_e;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

    prio_e              prio_q, prio_d;
    logic [3:0]         lock_cnt_q, lock_cnt_d;
    logic [MEM_LAT-1:0] pipe_valid_q, pipe_owner_q;
    logic               rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]  rdata0_q, rdata1_q;
    logic               tail_valid, tail_owner, rd_issue;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (m0_req && (!m1_req || prio_q == PRIO_M0)) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end

    assign mem_req = m0_gnt | m1_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Locked master-1 grants keep priority; the counter only advances while master 0 is starved.
    always_comb begin
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        if (m0_gnt) begin
            prio_d     = PRIO_M1;
            lock_cnt_d = '0;
        end else if (m1_gnt) begin
            if (m1_lock && lock_cnt_q < LOCK_LAST) begin
                prio_d = PRIO_M1;
                if (m0_req) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
            end else begin
                prio_d     = PRIO_M0;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= PRIO_M0;
            lock_cnt_q <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign rd_issue = mem_req & ~mem_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
        end else begin
            pipe_valid_q[0] <= rd_issue;
            pipe_owner_q[0] <= m1_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_owner_q[i] <= pipe_owner_q[i-1];
            end
        end
    end

    assign tail_valid = pipe_valid_q[MEM_LAT-1];
    assign tail_owner = pipe_owner_q[MEM_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tail_valid & ~tail_owner;
            rvalid1_q <= tail_valid & tail_owner;
            if (tail_valid && !tail_owner) begin
                rdata0_q <= mem_rdata;
            end
            if (tail_valid && tail_owner) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = m0_req | m1_req | (|pipe_valid_q);

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, m1_grant_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_q <= '0;
            m1_grant_cnt_q <= '0;
        end else begin
            if (m0_req && m1_req && conflict_cnt_q != '1) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (m1_gnt && m1_grant_cnt_q != '1) begin
                m1_grant_cnt_q <= m1_grant_cnt_q + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign m1_grant_cnt = m1_grant_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard testbench for dmem_arbiter: expected read returns are queued at the expected
// grant and popped when an rvalid appears; grant order and lock limits are checked inline.
module tb_dmem_arbiter;
    localparam int MEM_LAT  = 1;
    localparam int LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt, m1_grant_cnt;
`endif

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] exp_mem [64];
    logic [31:0] last_rdata [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt), .m1_grant_cnt(m1_grant_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [5:0] idx);
        if (idx == 6'd4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | {26'd0, idx};
    endfunction

    // Memory model: synchronous write, read data valid MEM_LAT cycles after the access.
    logic [31:0] tb_mem [64];
    logic [63:0] tb_written = '0;
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            tb_mem[mem_addr[7:2]]     <= mem_wdata;
            tb_written[mem_addr[7:2]] <= 1'b1;
        end
        rd_pipe[0] <= tb_written[mem_addr[7:2]] ? tb_mem[mem_addr[7:2]] : init_word(mem_addr[7:2]);
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Called at the negedge of the cycle in which the bench expects the read to be granted.
    task automatic push_read(input logic owner, input logic [31:0] addr);
        sb_t e;
        e.owner = owner;
        e.data  = exp_mem[addr[7:2]];
        e.due   = cyc + MEM_LAT + 1;
        sb_q.push_back(e);
    endtask

    task automatic monitor_returns();
        sb_t e;
        int  own, oth;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_rdata[0] = '0;
                last_rdata[1] = '0;
            end else if (m0_rvalid || m1_rvalid || (sb_q.size() > 0 && sb_q[0].due <= cyc)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: m0_rvalid=%0b m1_rvalid=%0b, required both 0 (cycle %0d)",
                             m0_rvalid, m1_rvalid, cyc);
                end else begin
                    e   = sb_q.pop_front();
                    own = e.owner ? 1 : 0;
                    oth = 1 - own;
                    if (m0_rvalid !== (own == 0) || m1_rvalid !== (own == 1) || e.due != cyc) begin
                        errors++;
                        $display("FAIL rvalid_route: m0_rvalid=%0b m1_rvalid=%0b cycle=%0d, required owner m%0d at cycle %0d",
                                 m0_rvalid, m1_rvalid, cyc, own, e.due);
                    end else if ((own == 1 ? m1_rdata : m0_rdata) !== e.data) begin
                        errors++;
                        $display("FAIL rdata: m%0d_rdata=%h, required %h", own,
                                 (own == 1 ? m1_rdata : m0_rdata), e.data);
                    end else if ((oth == 1 ? m1_rdata : m0_rdata) !== last_rdata[oth]) begin
                        errors++;
                        $display("FAIL rdata_hold: m%0d_rdata=%h, required %h", oth,
                                 (oth == 1 ? m1_rdata : m0_rdata), last_rdata[oth]);
                    end else begin
                        $display("return m%0d data=%h cycle=%0d", own, e.data, cyc);
                    end
                    last_rdata[own] = e.data;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt, mem_req, mem_we} !== 4'b0000) begin errors++;
            $display("FAIL reset_gnt: gnt/mem_req/mem_we=%b, required 0000", {m0_gnt, m1_gnt, mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata); end
        checks++; if ({m0_rvalid, m1_rvalid, busy} !== 3'b000) begin errors++;
            $display("FAIL reset_rvalid_busy: %b, required 000", {m0_rvalid, m1_rvalid, busy}); end
        checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin errors++;
            $display("FAIL reset_rdata: m0=%h m1=%h, required 0", m0_rdata, m1_rdata); end
    endtask

    task automatic test_single_read();
        next_cycle();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++;
            $display("FAIL single_gnt: m0_gnt=%b m1_gnt=%b, required 1 0", m0_gnt, m1_gnt); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin errors++;
            $display("FAIL single_mem: req=%b we=%b addr=%h, required 1 0 00000010", mem_req, mem_we, mem_addr); end
        push_read(1'b0, 32'h10);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL busy_inflight: busy=%b, required 1", busy); end
        repeat (4) next_cycle();
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, a1;
        logic        g1;
        apply_reset();
        a0 = 32'h20; a1 = 32'h30;
        m0_req = 1; m1_req = 1; m0_addr = a0; m1_addr = a1;
        for (int i = 0; i < 6; i++) begin
            g1 = (i % 2) == 1;
            @(negedge clk);
            checks++; if (m0_gnt !== !g1 || m1_gnt !== g1) begin errors++;
                $display("FAIL rr_gnt[%0d]: m0_gnt=%b m1_gnt=%b, required %b %b", i, m0_gnt, m1_gnt, !g1, g1); end
            checks++; if (mem_addr !== (g1 ? a1 : a0)) begin errors++;
                $display("FAIL rr_addr[%0d]: mem_addr=%h, required %h", i, mem_addr, (g1 ? a1 : a0)); end
            push_read(g1, g1 ? a1 : a0);
            next_cycle();
            if (g1) a1 = a1 + 32'd4; else a0 = a0 + 32'd4;
            m0_addr = a0; m1_addr = a1;
        end
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    task automatic test_lock_burst();
        m0_req = 1; m0_addr = 32'h14;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1) begin errors++;
            $display("FAIL lock_pre_gnt: m0_gnt=%b, required 1", m0_gnt); end
        push_read(1'b0, 32'h14);
        next_cycle();
        m0_addr = 32'h18;
        m1_req = 1; m1_we = 1; m1_lock = 1;
        for (int k = 0; k < LOCK_MAX; k++) begin
            m1_addr = 32'h80 + 32'(k * 4);
            m1_wdata = 32'h1000_0000 + 32'(k);
            @(negedge clk);
            checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++;
                $display("FAIL lock_burst_gnt[%0d]: m0_gnt=%b m1_gnt=%b, required 0 1", k, m0_gnt, m1_gnt); end
            checks++; if (mem_we !== 1'b1 || mem_addr !== m1_addr || mem_wdata !== m1_wdata) begin errors++;
                $display("FAIL lock_burst_wr[%0d]: we=%b addr=%h wdata=%h, required 1 %h %h",
                         k, mem_we, mem_addr, mem_wdata, m1_addr, m1_wdata); end
            exp_mem[m1_addr[7:2]] = m1_wdata;
            next_cycle();
        end
        m1_addr = 32'hF0; m1_wdata = 32'h1FFF_FFFF;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++;
            $display("FAIL lock_yield: m0_gnt=%b m1_gnt=%b, required 1 0", m0_gnt, m1_gnt); end
        push_read(1'b0, 32'h18);
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_lock_idle();
        m1_req = 1; m1_we = 1; m1_lock = 1;
        for (int k = 0; k < 20 + LOCK_MAX; k++) begin
            if (k == 20) begin m0_req = 1; m0_addr = 32'h1C; end
            m1_addr  = 32'h80 + 32'((k * 4) & 32'h7C);
            m1_wdata = 32'h2000_0000 + 32'(k);
            @(negedge clk);
            checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++;
                $display("FAIL lock_idle_gnt[%0d]: m0_gnt=%b m1_gnt=%b, required 0 1", k, m0_gnt, m1_gnt); end
            exp_mem[m1_addr[7:2]] = m1_wdata;
            next_cycle();
        end
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1) begin errors++;
            $display("FAIL lock_idle_yield: m0_gnt=%b, required 1", m0_gnt); end
        push_read(1'b0, 32'h1C);
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_readback();
        m1_req = 1; m1_addr = 32'h84;
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++;
            $display("FAIL readback_gnt: m1_gnt=%b mem_we=%b, required 1 0", m1_gnt, mem_we); end
        push_read(1'b1, 32'h84);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset_mid();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h88;
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b1) begin errors++;
            $display("FAIL mid_pre_gnt: m1_gnt=%b, required 1", m1_gnt); end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL mid_cleared: m0_rdata=%h m1_rdata=%h busy=%b, required 0 0 0", m0_rdata, m1_rdata, busy); end
        next_cycle();
        m0_req = 1; m0_addr = 32'h00; m1_req = 1; m1_addr = 32'h04;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++;
            $display("FAIL mid_prio: m0_gnt=%b m1_gnt=%b, required 1 0", m0_gnt, m1_gnt); end
        push_read(1'b0, 32'h00);
        next_cycle();
        m0_req = 0;
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b1) begin errors++;
            $display("FAIL mid_m1_after: m1_gnt=%b, required 1", m1_gnt); end
        push_read(1'b1, 32'h04);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        m0_req = 1; m0_addr = 32'h08; m1_req = 1; m1_addr = 32'h0C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_read((i % 2) == 1, (i % 2) == 1 ? 32'h0C : 32'h08);
            next_cycle();
        end
        m0_req = 0;
        @(negedge clk);
        push_read(1'b1, 32'h0C);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (conflict_cnt !== 32'd5 || m1_grant_cnt !== 32'd3) begin errors++;
            $display("FAIL perf_counts: conflict=%0d m1_grants=%0d, required 5 3", conflict_cnt, m1_grant_cnt); end
        repeat (4) next_cycle();
        apply_reset();
        @(negedge clk);
        checks++; if (conflict_cnt !== 32'd0 || m1_grant_cnt !== 32'd0) begin errors++;
            $display("FAIL perf_reset: conflict=%0d m1_grants=%0d, required 0 0", conflict_cnt, m1_grant_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(6'(i));
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        fork
            monitor_returns();
        join_none
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_lock_idle();
        test_readback();
        test_reset_mid();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        repeat (3) next_cycle();
        checks++; if (sb_q.size() != 0) begin errors++;
            $display("FAIL scoreboard_drain: %0d returns outstanding, required 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter for the single-port data memory of the CPU.
- Master 0 is the CPU load/store path; master 1 is a loader/DMA port that fills or dumps memory while the CPU runs or is halted.
- Issues at most one memory access per cycle and grants round-robin.
- Supports a bounded burst lock for master 1.
- Routes read data back to the originating master after a fixed memory latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_req to mem_rdata valid; legal range 1..4.
- LOCK_MAX, 8, maximum consecutive locked master-1 grants while master 0 waits; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU access request.
- m0_we  in  1  CPU write enable (1 = store).
- m0_addr  in  ADDR_W  CPU byte address.
- m0_wdata  in  DATA_W  CPU store data.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- m1_req  in  1  DMA access request.
- m1_we  in  1  DMA write enable.
- m1_lock  in  1  DMA requests to retain priority after this grant.
- m1_addr  in  ADDR_W  DMA address.
- m1_wdata  in  DATA_W  DMA write data.
- m1_gnt  out  1  DMA request accepted.
- m1_rvalid  out  1  DMA read data valid.
- m1_rdata  out  DATA_W  DMA read data.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req with mem_we = 0.
- busy  out  1  a read is in flight or any req is high.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - prio pointer selects master 0.
  - lock counter is 0.
  - Read-return pipeline is cleared.
  - m0_rvalid, m1_rvalid, m0_rdata and m1_rdata are 0.
  - gnt and mem_* outputs follow the combinational rules below; with both req low they are 0.
- Grant (combinational in the same cycle):
  - Only one master requesting: that master is granted, regardless of prio.
  - Both requesting: the master selected by prio is granted.
  - Never both gnt high in one cycle.
  - mem_req equals OR of gnts. mem_we, mem_addr and mem_wdata are muxed from the granted master; they are 0 when idle.
- Requester rule: a master holds req, we, addr and wdata stable until its gnt. The handshake completes in the cycle req and gnt are both high.
- Pointer update on a grant:
  - Default: prio points to the non-granted master.
  - Locked retain: if m1 is granted with m1_lock = 1 and lock counter < LOCK_MAX - 1, prio stays on m1 and the counter increments. The counter increments only while m0_req = 1; otherwise it holds.
  - Forced yield: when the counter reaches LOCK_MAX - 1 with m0 waiting, the next m1 grant flips prio to m0 and clears the counter.
  - Lock release: any m0 grant, or any m1 grant with m1_lock = 0, clears the counter.
- Read return:
  - MEM_LAT-deep shift register of {valid, owner}, loaded on each read grant.
  - At the tail, the owner's rvalid pulses for 1 cycle and rdata is registered from mem_rdata.
  - The other master's rvalid stays 0 and its rdata holds its last value.
  - Writes produce no rvalid.
  - Read latency is MEM_LAT + 1 cycles from grant to rvalid (1 register stage).
- Back-to-back: reads on consecutive cycles return on consecutive cycles, in order. Grants do not depend on return-pipeline occupancy.
- Reset mid-operation: in-flight reads are discarded, no rvalid is emitted, and prio returns to m0.
- busy is combinational: any req, or any valid bit in the return pipeline.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, the block adds:
  - Output ports conflict_cnt (32) and m1_grant_cnt (32).
  - conflict_cnt increments each cycle both req are high.
  - m1_grant_cnt increments on each m1 grant.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then m0 read addr 0x10 with mem_rdata = 0xDEADBEEF (MEM_LAT = 1) -> m0_gnt in the request cycle, m0_rvalid 2 cycles later with m0_rdata = 0xDEADBEEF, m1_rvalid stays 0.
- Both masters request reads continuously for 6 cycles, lock = 0 -> grants alternate m0,m1,m0,m1,m0,m1; rvalids return in the same order.
- m1 write burst with m1_lock = 1 and m0 requesting, LOCK_MAX = 8 -> m1 granted 8 consecutive cycles, then m0 granted; counter cleared.
- m1 alone with lock = 1 for 20 cycles, then m0 requests -> m1 granted every cycle; m0 waits at most 8 m1 grants.
- Reset asserted 1 cycle after an m1 read grant with MEM_LAT = 3 -> no m1_rvalid ever appears; the next simultaneous request grants m0.
- With DMEM_ARB_PERF_EN, 5 conflict cycles and 3 m1 grants -> conflict_cnt = 5, m1_grant_cnt = 3; reset -> both counters 0.
